// File: rtl/sbqm_pkg.sv
// Shared types and constants for the SBqM teller dispatcher.
// Holds the FSM state enum, teller count and round-robin helpers.
package sbqm_pkg;

  localparam int unsigned N_TELLERS = 3;
  localparam logic [1:0] CALL_IDLE = 2'd0;

  typedef enum logic [1:0] {
    StIdle,
    StAnnounce,
    StSettle
  } state_e;

  // Teller i is open when i < t_count.
  function automatic logic [N_TELLERS-1:0] open_mask(logic [1:0] t_count);
    logic [N_TELLERS-1:0] m;
    for (int unsigned i = 0; i < N_TELLERS; i++) begin
      m[i] = (i < 32'(t_count));
    end
    return m;
  endfunction

  // Candidate index k steps after ptr, wrapping over the tellers.
  function automatic logic [1:0] rr_idx(logic [1:0] ptr, int unsigned k);
    int unsigned s;
    s = (32'(ptr) + k) % N_TELLERS;
    return s[1:0];
  endfunction

endpackage

// File: rtl/sbqm_teller_dispatcher_if.sv
// Queue/teller-side signal bundle of the dispatcher.
// master: the dispatcher itself; slave: the SBqM front end and tellers.
interface sbqm_teller_dispatcher_if #(
  parameter int unsigned SERVED_W = 8
);
  logic [1:0]          T_Count;
  logic                q_empt;
  logic [2:0]          teller_done;
  logic                q_pop;
  logic                call_valid;
  logic [1:0]          call_teller;
  logic [2:0]          teller_busy;
  logic [SERVED_W-1:0] served;

  modport master (
    input  T_Count, q_empt, teller_done,
    output q_pop, call_valid, call_teller, teller_busy, served
  );

  modport slave (
    output T_Count, q_empt, teller_done,
    input  q_pop, call_valid, call_teller, teller_busy, served
  );
endinterface

// File: rtl/sbqm_rr_arbiter.sv
// Combinational 3-way round-robin picker.
// Searches req_i starting one past ptr_i, wrapping; the pointer lives in the parent.
module sbqm_rr_arbiter
  import sbqm_pkg::*;
(
  input  logic [N_TELLERS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [1:0]           gnt_idx_o,
  output logic                 gnt_valid_o
);

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned k = 1; k <= N_TELLERS; k++) begin
      if (!gnt_valid_o && req_i[rr_idx(ptr_i, k)]) begin
        gnt_idx_o   = rr_idx(ptr_i, k);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbqm_teller_dispatcher.sv
// Teller dispatcher: pops the SBqM queue into a free open teller round-robin,
// shows the call for ANNOUNCE_CYC cycles, and tracks per-teller busy state.
module sbqm_teller_dispatcher
  import sbqm_pkg::*;
#(
  parameter int unsigned ANNOUNCE_CYC = 4,
  parameter int unsigned SERVED_W     = 8
) (
  input logic                     clck,
  input logic                     rst,
  sbqm_teller_dispatcher_if.master bus
);

  localparam int unsigned CntW = (ANNOUNCE_CYC > 1) ? $clog2(ANNOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ANNOUNCE_CYC - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             rr_q, rr_d;
  logic [N_TELLERS-1:0]   busy_q, busy_d;
  logic [SERVED_W-1:0]    served_q, served_d;
  logic                   pop_q, pop_d;
  logic                   call_valid_q, call_valid_d;
  logic [1:0]             call_teller_q, call_teller_d;

  logic [N_TELLERS-1:0]   free;
  logic [1:0]             gnt_idx;
  logic                   gnt_valid;

  assign free = open_mask(bus.T_Count) & ~busy_q;

  sbqm_rr_arbiter u_arb (
    .req_i       (free),
    .ptr_i       (rr_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    busy_d        = busy_q & ~bus.teller_done;
    served_d      = served_q;
    pop_d         = 1'b0;
    call_valid_d  = 1'b0;
    call_teller_d = CALL_IDLE;
    unique case (state_q)
      StIdle: begin
        if (!bus.q_empt && gnt_valid) begin
          state_d         = StAnnounce;
          cnt_d           = CntLoad;
          pop_d           = 1'b1;
          call_valid_d    = 1'b1;
          call_teller_d   = gnt_idx + 2'd1;
          rr_d            = gnt_idx;
          busy_d[gnt_idx] = 1'b1;
          if (served_q != '1) served_d = served_q + 1'b1;
        end
      end
      StAnnounce: begin
        // Last announce cycle drops the display; SETTLE lets the queue count settle.
        if (cnt_q == '0) begin
          state_d = StSettle;
        end else begin
          cnt_d         = cnt_q - 1'b1;
          call_valid_d  = 1'b1;
          call_teller_d = call_teller_q;
        end
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rr_q          <= 2'd2;
      busy_q        <= '0;
      served_q      <= '0;
      pop_q         <= 1'b0;
      call_valid_q  <= 1'b0;
      call_teller_q <= CALL_IDLE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      busy_q        <= busy_d;
      served_q      <= served_d;
      pop_q         <= pop_d;
      call_valid_q  <= call_valid_d;
      call_teller_q <= call_teller_d;
    end
  end

  assign bus.q_pop       = pop_q;
  assign bus.call_valid  = call_valid_q;
  assign bus.call_teller = call_teller_q;
  assign bus.teller_busy = busy_q;
  assign bus.served      = served_q;

endmodule

// File: tb/tb_sbqm_teller_dispatcher.sv
// Bench for sbqm_teller_dispatcher: phase-based reference model checked every
// cycle, plus directed literal checks at hand-computed points.
module tb_sbqm_teller_dispatcher;

  localparam int A = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbqm_teller_dispatcher_if #(.SERVED_W(8)) bus ();

  sbqm_teller_dispatcher #(
    .ANNOUNCE_CYC (A),
    .SERVED_W     (8)
  ) dut (
    .clck (clk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: phase 0 = waiting, 1..A = call on display, A+1 = settle gap.
  int         m_phase  = 0;
  logic [2:0] m_busy   = '0;
  logic [1:0] m_rr     = 2'd2;
  logic [1:0] m_call   = '0;
  logic [7:0] m_served = '0;
  logic [2:0] m_open, m_free, m_nb;
  int         m_g;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = 0; m_busy = '0; m_rr = 2'd2; m_call = '0; m_served = '0;
    end else begin
      for (int i = 0; i < 3; i++) m_open[i] = (i < int'(bus.T_Count));
      m_free = m_open & ~m_busy;
      m_nb   = m_busy & ~bus.teller_done;
      if (m_phase == 0) begin
        m_g = -1;
        for (int k = 1; k <= 3; k++)
          if (m_g < 0 && m_free[(int'(m_rr) + k) % 3]) m_g = (int'(m_rr) + k) % 3;
        if (!bus.q_empt && m_g >= 0) begin
          m_nb[m_g] = 1'b1;
          m_rr      = 2'(m_g);
          m_call    = 2'(m_g + 1);
          if (m_served != 8'hFF) m_served = m_served + 8'd1;
          m_phase   = 1;
        end
      end else if (m_phase == A + 1) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
      m_busy = m_nb;
    end
  end

  always @(negedge clk) begin
    logic exp_cv;
    exp_cv = (m_phase >= 1 && m_phase <= A);
    chk("cmp_q_pop",       32'(bus.q_pop),       32'(m_phase == 1));
    chk("cmp_call_valid",  32'(bus.call_valid),  32'(exp_cv));
    chk("cmp_call_teller", 32'(bus.call_teller), exp_cv ? 32'(m_call) : 32'd0);
    chk("cmp_teller_busy", 32'(bus.teller_busy), 32'(m_busy));
    chk("cmp_served",      32'(bus.served),      32'(m_served));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pops;
    rst = 1'b0; bus.T_Count = 2'd3; bus.q_empt = 1'b0; bus.teller_done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_q_pop", 32'(bus.q_pop), 32'd0);
      chk("rst_busy", 32'(bus.teller_busy), 32'd0);
      chk("rst_served", 32'(bus.served), 32'd0);
      chk("rst_call_teller", 32'(bus.call_teller), 32'd0);
    end
    rst = 1'b1;

    // Single dispatch to teller 1.
    tick(1);
    chk("d1_pop", 32'(bus.q_pop), 32'd1);
    chk("d1_teller", 32'(bus.call_teller), 32'd1);
    chk("d1_busy", 32'(bus.teller_busy), 32'b001);
    chk("d1_served", 32'(bus.served), 32'd1);
    tick(1);
    chk("d1_pop_low", 32'(bus.q_pop), 32'd0);
    tick(2);
    chk("d1_cv_last", 32'(bus.call_valid), 32'd1);
    tick(1);
    chk("d1_settle_cv", 32'(bus.call_valid), 32'd0);
    chk("d1_settle_teller", 32'(bus.call_teller), 32'd0);

    // Round robin at 6-cycle spacing.
    tick(2);
    chk("rr2_pop", 32'(bus.q_pop), 32'd1);
    chk("rr2_teller", 32'(bus.call_teller), 32'd2);
    tick(6);
    chk("rr3_pop", 32'(bus.q_pop), 32'd1);
    chk("rr3_teller", 32'(bus.call_teller), 32'd3);
    chk("rr3_busy", 32'(bus.teller_busy), 32'b111);
    chk("rr3_served", 32'(bus.served), 32'd3);
    tick(12);
    chk("full_no_pop", 32'(bus.q_pop), 32'd0);
    chk("full_busy", 32'(bus.teller_busy), 32'b111);

    // Completion and reuse of teller 2.
    bus.teller_done = 3'b010;
    tick(1);
    bus.teller_done = 3'b000;
    chk("done_busy", 32'(bus.teller_busy), 32'b101);
    tick(1);
    chk("reuse_pop", 32'(bus.q_pop), 32'd1);
    chk("reuse_teller", 32'(bus.call_teller), 32'd2);
    chk("reuse_busy", 32'(bus.teller_busy), 32'b111);
    chk("reuse_served", 32'(bus.served), 32'd4);

    // Only teller 1 open.
    tick(5);
    bus.T_Count = 2'd1; bus.teller_done = 3'b111;
    tick(1);
    bus.teller_done = 3'b000;
    chk("t1_cleared", 32'(bus.teller_busy), 32'b000);
    tick(1);
    chk("t1_pop", 32'(bus.q_pop), 32'd1);
    chk("t1_teller", 32'(bus.call_teller), 32'd1);
    tick(12);
    chk("t1_wait_served", 32'(bus.served), 32'd5);
    chk("t1_wait_busy", 32'(bus.teller_busy), 32'b001);
    bus.teller_done = 3'b001;
    tick(1);
    bus.teller_done = 3'b000;
    tick(1);
    chk("t1_second_pop", 32'(bus.q_pop), 32'd1);
    chk("t1_second_teller", 32'(bus.call_teller), 32'd1);
    chk("t1_second_served", 32'(bus.served), 32'd6);

    // No tellers open.
    bus.T_Count = 2'd0;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pops += int'(bus.q_pop);
      bus.teller_done = (i == 0) ? 3'b001 : 3'b000;
    end
    chk("t0_no_pops", 32'(pops), 32'd0);
    chk("t0_busy", 32'(bus.teller_busy), 32'b000);

    // Reset during the second announce cycle.
    bus.T_Count = 2'd3;
    tick(1);
    chk("pre_rst_teller", 32'(bus.call_teller), 32'd2);
    chk("pre_rst_served", 32'(bus.served), 32'd7);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_pop", 32'(bus.q_pop), 32'd0);
    chk("mid_rst_cv", 32'(bus.call_valid), 32'd0);
    chk("mid_rst_teller", 32'(bus.call_teller), 32'd0);
    chk("mid_rst_busy", 32'(bus.teller_busy), 32'd0);
    chk("mid_rst_served", 32'(bus.served), 32'd0);
    rst = 1'b1; bus.q_empt = 1'b1;

    // Empty queue with free tellers.
    pops = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      pops += int'(bus.q_pop);
    end
    chk("empty_no_pops", 32'(pops), 32'd0);
    bus.q_empt = 1'b0;
    tick(1);
    chk("post_rst_teller", 32'(bus.call_teller), 32'd1);
    chk("post_rst_pop", 32'(bus.q_pop), 32'd1);
    bus.q_empt = 1'b1;
    tick(3);
    chk("empt_rise_cv", 32'(bus.call_valid), 32'd1);
    chk("empt_rise_teller", 32'(bus.call_teller), 32'd1);
    tick(1);
    chk("empt_rise_settle", 32'(bus.call_valid), 32'd0);
    tick(6);
    chk("empt_final_served", 32'(bus.served), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
